// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared video types and constants for the frame-buffer -> VGA pixel path.
//   rgb444_t       : 12-bit pixel {R[11:8], G[7:4], B[3:0]}
//   luma_t         : 7-bit luma, 0..120
//   DEF_H_PIX/V_PIX: default active frame size (320x240)
//   DEF_THRESH     : default Sobel edge threshold
//   EDGE_PIX/BG_PIX: white / black output pixels
//   sobel_state_t  : frame-tracking states of the edge filter
//   rgb_to_luma()  : Y = 2R + 5G + B
// ---------------------------------------------------------------------------
package video_pkg;

    typedef logic [11:0] rgb444_t;
    typedef logic [6:0]  luma_t;

    localparam int          DEF_H_PIX  = 320;
    localparam int          DEF_V_PIX  = 240;
    localparam logic [10:0] DEF_THRESH = 11'd200;

    localparam rgb444_t EDGE_PIX = 12'hFFF;
    localparam rgb444_t BG_PIX   = 12'h000;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } sobel_state_t;

    // Max 2*15 + 5*15 + 15 = 120, so 7-bit arithmetic never overflows.
    function automatic luma_t rgb_to_luma(input rgb444_t p);
        luma_t r;
        luma_t g;
        luma_t b;
        r = {3'b000, p[11:8]};
        g = {3'b000, p[7:4]};
        b = {3'b000, p[3:0]};
        return (r << 1) + (g * 7'd5) + b;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// ---------------------------------------------------------------------------
// sobel_line_buffer
// One video line of luma samples (DEPTH x 7) with combinational read and
// synchronous write, so a read-modify-write of the same column completes in
// one pixel cycle. Contents are never cleared.
//   clk25 : pixel clock
//   we    : write enable
//   addr  : column address (shared by read and write)
//   wdata : luma written at the rising edge when we=1
//   rdata : luma currently stored at addr
// ---------------------------------------------------------------------------
module sobel_line_buffer
    import video_pkg::*;
#(
    parameter int DEPTH = DEF_H_PIX,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk25,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  luma_t         wdata,
    output luma_t         rdata
);

    luma_t mem [DEPTH];

    always_ff @(posedge clk25) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_edge_filter.sv
// ---------------------------------------------------------------------------
// sobel_edge_filter
// Streaming 3x3 Sobel edge detector on an RGB444 pixel stream. Each pixel is
// converted to luma, a 3x3 window is built from two line buffers, and the
// output is EDGE_PIX when |Gx|+|Gy| > THRESH, BG_PIX otherwise. The result
// for input (c,r) belongs to window centre (c-1,r-1); windows touching the
// left/top border (c<2 or r<2) are forced to BG_PIX. Fixed 2-cycle latency.
//   clk25     : pixel clock
//   reset     : synchronous, active-high
//   in_valid  : in_data carries an active pixel
//   in_sof    : first pixel of a frame (qualified by in_valid)
//   in_data   : RGB444 pixel
//   bypass    : only with SOBEL_BYPASS_EN; 1 = out_data is in_data delayed 2
//   out_valid : in_valid delayed 2 cycles
//   out_data  : filtered (or bypassed) pixel
// Optional feature macro: SOBEL_BYPASS_EN
// ---------------------------------------------------------------------------
module sobel_edge_filter
    import video_pkg::*;
#(
    parameter int          H_PIX  = DEF_H_PIX,
    parameter int          V_PIX  = DEF_V_PIX,
    parameter logic [10:0] THRESH = DEF_THRESH
) (
    input  logic    clk25,
    input  logic    reset,
    input  logic    in_valid,
    input  logic    in_sof,
    input  rgb444_t in_data,
`ifdef SOBEL_BYPASS_EN
    input  logic    bypass,
`endif
    output logic    out_valid,
    output rgb444_t out_data
);

    localparam int CW = $clog2(H_PIX);
    localparam int RW = $clog2(V_PIX);

    // ---------------- frame position tracking ----------------
    sobel_state_t  state_reg, state_next;
    logic [CW-1:0] col_reg, col_next, pix_col;
    logic [RW-1:0] row_reg, row_next, pix_row;
    logic          frame_pix;

    always_ff @(posedge clk25) begin
        if (reset) begin
            state_reg <= WAIT_SOF;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        if (frame_pix) begin
            state_next = ACTIVE;
            if (pix_col == CW'(H_PIX - 1)) begin
                col_next = '0;
                if (pix_row == RW'(V_PIX - 1)) begin
                    row_next   = '0;
                    state_next = WAIT_SOF;
                end else begin
                    row_next = pix_row + RW'(1);
                end
            end else begin
                col_next = pix_col + CW'(1);
                row_next = pix_row;
            end
        end
    end

    // A valid SOF restarts the frame at (0,0) from any state, even mid-frame.
    always_comb begin
        frame_pix = in_valid && (in_sof || (state_reg == ACTIVE));
        pix_col   = (in_valid && in_sof) ? '0 : col_reg;
        pix_row   = (in_valid && in_sof) ? '0 : row_reg;
    end

    // ---------------- line buffers ----------------
    // lb[0] holds row r-1, lb[1] holds row r-2. Both shift down on each
    // in-frame pixel: lb1[c] <- lb0[c], lb0[c] <- Y.
    luma_t y;
    luma_t lb_rd [2];
    luma_t lb_wd [2];

    assign y        = rgb_to_luma(in_data);
    assign lb_wd[0] = y;
    assign lb_wd[1] = lb_rd[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_lb
            sobel_line_buffer #(
                .DEPTH (H_PIX),
                .AW    (CW)
            ) u_lb (
                .clk25 (clk25),
                .we    (frame_pix),
                .addr  (pix_col),
                .wdata (lb_wd[gi]),
                .rdata (lb_rd[gi])
            );
        end
    endgenerate

    // ---------------- stage 1: window shift ----------------
    // win_reg[row][col]; row 2 / col 2 are the newest samples.
    luma_t   win_reg [3][3];
    luma_t   new_col [3];
    logic    valid1_reg;
    logic    mask1_reg;

    assign new_col[0] = lb_rd[1];
    assign new_col[1] = lb_rd[0];
    assign new_col[2] = y;

    always_ff @(posedge clk25) begin
        if (frame_pix) begin
            for (int i = 0; i < 3; i++) begin
                win_reg[i][0] <= win_reg[i][1];
                win_reg[i][1] <= win_reg[i][2];
                win_reg[i][2] <= new_col[i];
            end
        end
    end

    // Mask out-of-frame pixels and border windows; stale line-buffer and
    // window contents are only ever seen through this mask.
    always_ff @(posedge clk25) begin
        if (reset) begin
            valid1_reg <= 1'b0;
            mask1_reg  <= 1'b1;
        end else begin
            valid1_reg <= in_valid;
            mask1_reg  <= !(frame_pix && (pix_col >= CW'(2)) && (pix_row >= RW'(2)));
        end
    end

`ifdef SOBEL_BYPASS_EN
    logic    byp1_reg;
    rgb444_t data1_reg;

    always_ff @(posedge clk25) begin
        if (reset) begin
            byp1_reg  <= 1'b0;
            data1_reg <= BG_PIX;
        end else begin
            byp1_reg  <= bypass;
            data1_reg <= in_data;
        end
    end
`endif

    // ---------------- stage 2: gradient and threshold ----------------
    function automatic logic [9:0] wsum(input luma_t a, input luma_t b, input luma_t c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    // Each weighted sum is <= 480, so bit 9 is clear and the subtraction
    // fits a 10-bit signed result of +/-480.
    logic signed [9:0] gx, gy;
    logic [9:0]        gx_abs, gy_abs;
    logic [10:0]       mag;
    rgb444_t           filt_pix;

    always_comb begin
        gx = $signed(wsum(win_reg[0][2], win_reg[1][2], win_reg[2][2]))
           - $signed(wsum(win_reg[0][0], win_reg[1][0], win_reg[2][0]));
        gy = $signed(wsum(win_reg[2][0], win_reg[2][1], win_reg[2][2]))
           - $signed(wsum(win_reg[0][0], win_reg[0][1], win_reg[0][2]));
        gx_abs   = gx[9] ? 10'(-gx) : 10'(gx);
        gy_abs   = gy[9] ? 10'(-gy) : 10'(gy);
        mag      = {1'b0, gx_abs} + {1'b0, gy_abs};
        filt_pix = (!mask1_reg && (mag > THRESH)) ? EDGE_PIX : BG_PIX;
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= BG_PIX;
        end else begin
            out_valid <= valid1_reg;
`ifdef SOBEL_BYPASS_EN
            out_data  <= byp1_reg ? data1_reg : filt_pix;
`else
            out_data  <= filt_pix;
`endif
        end
    end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// ---------------------------------------------------------------------------
// tb_sobel_edge_filter
// Two filter instances share one input stream: dut_a with THRESH=200 and
// dut_b with THRESH=480 (strict-compare boundary). A reduced frame size keeps
// runs short. The reference model keeps a luma image of the current frame and
// evaluates the Sobel kernel directly on it.
// Optional feature macro: SOBEL_BYPASS_EN
// ---------------------------------------------------------------------------
module tb_sobel_edge_filter;
    import video_pkg::*;

    localparam int H = 24;
    localparam int V = 16;

    logic    clk25 = 1'b0;
    logic    reset;
    logic    in_valid;
    logic    in_sof;
    rgb444_t in_data;
    logic    byp;
    logic    ov_a, ov_b;
    rgb444_t od_a, od_b;

    always #20 clk25 = ~clk25;

    sobel_edge_filter #(.H_PIX(H), .V_PIX(V), .THRESH(11'd200)) dut_a (
        .clk25    (clk25),
        .reset    (reset),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_data  (in_data),
`ifdef SOBEL_BYPASS_EN
        .bypass   (byp),
`endif
        .out_valid(ov_a),
        .out_data (od_a)
    );

    sobel_edge_filter #(.H_PIX(H), .V_PIX(V), .THRESH(11'd480)) dut_b (
        .clk25    (clk25),
        .reset    (reset),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_data  (in_data),
`ifdef SOBEL_BYPASS_EN
        .bypass   (byp),
`endif
        .out_valid(ov_b),
        .out_data (od_b)
    );

    int      vectors = 0;
    int      miscompares = 0;
    string   cur_tag;

    // reference model state
    int      img [V][H];
    bit      m_active;
    int      m_col, m_row;
    rgb444_t frame [V][H];

    // expectation for the outputs one step later
    bit      pv;
    bit      pchk;
    rgb444_t pa, pb;

    bit      cap_en;
    rgb444_t q_cap[$];
    rgb444_t q_ref[$];

    function automatic int luma(input rgb444_t p);
        return 2 * int'(p[11:8]) + 5 * int'(p[7:4]) + int'(p[3:0]);
    endfunction

    function automatic rgb444_t model_edge(input int c, input int r, input int thr);
        int w [3] = '{1, 2, 1};
        int gx = 0;
        int gy = 0;
        int mag;
        if (c < 2 || r < 2) return 12'h000;
        for (int i = 0; i < 3; i++) begin
            gx += w[i] * (img[r-2+i][c] - img[r-2+i][c-2]);
            gy += w[i] * (img[r][c-2+i] - img[r-2][c-2+i]);
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > thr) ? 12'hFFF : 12'h000;
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s/%s: observed %h expected %h", cur_tag, name, got, exp);
        end
    endtask

    // One pixel-clock step: drive inputs, update model, check the outputs
    // that belong to the previous step's inputs.
    task automatic step(input bit rst, input bit v, input bit sof, input rgb444_t d);
        bit      cv, cchk;
        rgb444_t ca, cb;
        reset = rst; in_valid = v; in_sof = sof; in_data = d;
        ca = 12'h000; cb = 12'h000;
        if (rst) begin
            m_active = 0; m_col = 0; m_row = 0;
            cv = 0; cchk = 1;
        end else if (v) begin
            cv = 1; cchk = 1;
            if (sof) begin
                m_active = 1; m_col = 0; m_row = 0;
            end
            if (m_active) begin
                img[m_row][m_col] = luma(d);
                ca = model_edge(m_col, m_row, 200);
                cb = model_edge(m_col, m_row, 480);
                m_col++;
                if (m_col == H) begin
                    m_col = 0;
                    m_row++;
                    if (m_row == V) begin
                        m_row = 0;
                        m_active = 0;
                    end
                end
            end
            if (byp) begin
                ca = d; cb = d;
            end
        end else begin
            cv = 0; cchk = 0;
        end
        @(posedge clk25);
        #1;
        if (rst) begin
            check("rst_valid_a", {11'b0, ov_a}, 12'h000);
            check("rst_data_a", od_a, 12'h000);
            check("rst_valid_b", {11'b0, ov_b}, 12'h000);
        end else begin
            check("valid_a", {11'b0, ov_a}, {11'b0, pv});
            check("valid_b", {11'b0, ov_b}, {11'b0, pv});
            if (pchk) begin
                check("data_a", od_a, pa);
                check("data_b", od_b, pb);
            end
        end
        if (cap_en && ov_a) q_cap.push_back(od_a);
        pv = cv; pchk = cchk; pa = ca; pb = cb;
    endtask

    task automatic flush();
        step(0, 0, 0, 12'h000);
        step(0, 0, 0, 12'h000);
    endtask

    task automatic run_frame(input bit bubbles, input int byp_rows);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                if (bubbles) begin
                    while ($urandom_range(0, 2) == 0) step(0, 0, 0, 12'($urandom));
                end
`ifdef SOBEL_BYPASS_EN
                byp = (r < byp_rows);
`endif
                step(0, 1, (r == 0 && c == 0), frame[r][c]);
            end
        end
        byp = 0;
        flush();
    endtask

    task automatic fill_random();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                frame[r][c] = 12'($urandom);
    endtask

    initial begin
        int n;
        byp = 0; cap_en = 0;
        pv = 0; pchk = 0; pa = 0; pb = 0;
        reset = 1; in_valid = 0; in_sof = 0; in_data = 0;

        // reset with in_valid held high, then pixels before any SOF
        cur_tag = "reset";
        for (int i = 0; i < 3; i++) step(1, 1, 0, 12'($urandom));
        for (int i = 0; i < 4; i++) step(0, 1, 0, 12'($urandom));
        $display("section reset: done");

        cur_tag = "pre_sof";
        for (int i = 0; i < 20; i++) step(0, ($urandom_range(0, 3) != 0), 0, 12'($urandom));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 12'($urandom));  // SOF without valid is ignored
        for (int i = 0; i < 5; i++) step(0, 1, 0, 12'($urandom));
        $display("section pre_sof: done");

        // uniform frame: no edges anywhere
        cur_tag = "uniform";
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                frame[r][c] = 12'h888;
        run_frame(0, 0);
        $display("section uniform: done");

        // vertical step: edges exactly at centre x = H/2-1, H/2 for dut_a only
        cur_tag = "vstep";
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                frame[r][c] = (c < H/2) ? 12'h000 : 12'hFFF;
        q_cap.delete(); cap_en = 1;
        run_frame(0, 0);
        cap_en = 0;
        n = 0;
        foreach (q_cap[i]) if (q_cap[i] == 12'hFFF) n++;
        check("edge_count", 12'(n), 12'(2 * (V - 2)));
        check("out_count", 12'(q_cap.size()), 12'(H * V));
        $display("section vstep: done");

        // random frames
        cur_tag = "random";
        for (int k = 0; k < 2; k++) begin
            fill_random();
            run_frame(0, 0);
        end
        $display("section random: done");

        // SOF in the middle of a frame restarts the counters there
        cur_tag = "mid_sof";
        fill_random();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < H; c++)
                if (r < 5 || c < 10) step(0, 1, (r == 0 && c == 0), frame[r][c]);
        fill_random();
        run_frame(0, 0);
        $display("section mid_sof: done");

        // bubbles must not change the output sequence
        cur_tag = "bubbles";
        fill_random();
        q_cap.delete(); cap_en = 1;
        run_frame(0, 0);
        q_ref = q_cap;
        q_cap.delete();
        run_frame(1, 0);
        cap_en = 0;
        check("seq_len", 12'(q_cap.size()), 12'(q_ref.size()));
        if (q_cap.size() == q_ref.size())
            foreach (q_ref[i]) check("seq_pix", q_cap[i], q_ref[i]);
        $display("section bubbles: done");

        // reset mid-frame flushes the pipeline and returns to WAIT_SOF
        cur_tag = "mid_reset";
        fill_random();
        for (int i = 0; i < 50; i++) step(0, 1, (i == 0), frame[i / H][i % H]);
        step(1, 0, 0, 12'h000);
        step(1, 0, 0, 12'h000);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 12'h000);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 12'($urandom));
        flush();
        $display("section mid_reset: done");

`ifdef SOBEL_BYPASS_EN
        cur_tag = "bypass";
        byp = 1;
        for (int i = 0; i < 40; i++)
            step(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 12'($urandom));
        byp = 0;
        flush();
        fill_random();
        run_frame(0, 4);
        $display("section bypass: done");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sobel_edge_filter.md
# sobel_edge_filter

Streaming 3x3 Sobel edge detector that sits between the frame-buffer read port and the VGA timing stage's pixel input. It consumes the 320x240 RGB444 pixel stream read from the frame buffer and converts each pixel to luma. It emits a thresholded edge map, white on black, as RGB444 in the same stream order with a fixed 2-cycle latency. Integration advances the frame-buffer read address by 2 so the VGA window stays aligned.

## Interface
- `H_PIX`, 320: active pixels per line.
- `V_PIX`, 240: active lines per frame.
- `THRESH`, 200: edge threshold, 11-bit unsigned; a pixel is an edge iff magnitude > THRESH.
- `clk25`  in  1  25 MHz pixel clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` carries an active pixel this cycle.
- `in_sof`  in  1  qualifies the first pixel of a frame; ignored unless `in_valid`.
- `in_data`  in  12  RGB444 pixel {R[11:8], G[7:4], B[3:0]}.
- `bypass`  in  1  present only with `SOBEL_BYPASS_EN`.
- `out_valid`  out  1  `in_valid` delayed 2 cycles.
- `out_data`  out  12  filtered pixel: 12'hFFF for an edge, 12'h000 otherwise.

## Operation
- Luma: Y = 2R + 5G + B, 7-bit unsigned, range 0..120.
- Two line buffers, each H_PIX x 7, with combinational read and registered write.
- On an accepted pixel at (c,r): read lb0[c] (row r-1) and lb1[c] (row r-2), write lb1[c] ← lb0[c], write lb0[c] ← Y.
- The window shift registers take a new column {lb1[c], lb0[c], Y}. p[row][col] has row 2 and col 2 newest.
- Gx = (p02+2p12+p22) − (p00+2p10+p20); Gy = (p20+2p21+p22) − (p00+2p01+p02). Both are 10-bit signed, ±480.
- mag = |Gx| + |Gy|, 11-bit unsigned, max 960, with no saturation needed.
- The output for input (c,r) is the result for window centre (c−1, r−1).
- Border masking: if c<2 or r<2, out_data = 0 regardless of window contents. Line buffers are never cleared; masking covers stale data.
- State machine:
  - WAIT_SOF: pixels are passed through as valid with out_data = 0; counters are held.
  - ACTIVE: counters advance. col wraps H_PIX−1→0 and increments row. After the pixel at (H_PIX−1, V_PIX−1) the state goes to WAIT_SOF.
- `in_valid && in_sof` in any state, including mid-frame, forces (c,r) = (0,0) for that pixel and enters ACTIVE.
- `in_valid` low: no counter, line-buffer or window update. Bubbles are allowed anywhere.

## Timing
- Latency: `in_valid` in cycle n gives `out_valid` in cycle n+2, every cycle, with no backpressure.
- Stage 1 (edge ending cycle n): luma, line-buffer access, window shift, border flag registered.
- Stage 2 (edge ending n+1): gradient, magnitude, compare, output register.
- Reset values: out_valid=0, out_data=0, state=WAIT_SOF, col=0, row=0, pipeline valid bits 0.
- Reset asserted mid-frame: the pipeline is flushed. out_valid is 0 in the two cycles after reset deasserts unless new input arrives.

## Configuration
- `SOBEL_BYPASS_EN` defined: the `bypass` port exists. When `bypass`=1 (sampled alongside stage 1), out_data = in_data delayed by exactly 2 cycles, ignoring state and masking. Line buffers and counters keep updating, so toggling `bypass` mid-frame does not corrupt the next filtered line.
- `SOBEL_BYPASS_EN` undefined: no port, filter always active.

## Structure
- Shared package `video_pkg`:
  - `rgb444_t` (12-bit).
  - `luma_t` (7-bit).
  - H_PIX/V_PIX default constants.
  - `EDGE_PIX` = 12'hFFF.
  - `BG_PIX` = 12'h000.
- Sub-module `sobel_line_buffer`: H_PIX x 7 LUTRAM with combinational read and synchronous write. The filter instantiates it twice.

## Test plan
- Reset with `in_valid` held high → out_valid=0 and out_data=0 for 2 cycles after release, then out_valid=1.
- Pixels before any `in_sof` → out_valid follows in_valid with 2-cycle delay; out_data=12'h000.
- Uniform 12'h888 frame → every out_data=12'h000.
- Vertical step: cols <160 = 12'h000, cols ≥160 = 12'hFFF. Expect out_data=12'hFFF exactly at centre x=159,160 for centre rows 1..238 (mag 480), and 0 elsewhere. Rerun with THRESH=480 → all 0 (strict compare).
- `in_sof` asserted at pixel (100,50) → counters restart there and outputs for the next 2 lines are masked. Also insert random `in_valid` bubbles → identical output sequence to the bubble-free run.
- With `SOBEL_BYPASS_EN`, `bypass`=1 → out_data equals in_data delayed 2 cycles for an arbitrary pattern.
